// File: rtl/frame_reader_pkg.sv
// Frame-buffer package shared by the fill and read paths.
// Holds the default frame geometry, DDR2 command encodings, request-FSM
// state encodings and the read-address packing helper.
package frame_reader_pkg;

   localparam logic [9:0]  FB_BASE   = 10'b0001000001;
   localparam int unsigned H_PIXELS  = 800;
   localparam int unsigned V_LINES   = 600;
   localparam int unsigned BUF_DEPTH = 16;

   localparam logic [2:0] DDR_CMD_READ  = 3'b001;
   localparam logic [2:0] DDR_CMD_WRITE = 3'b000;

   // One burst is two 128-bit beats; each beat carries four 32-bit lanes
   // of which only the low 24 bits are pixel data.
   localparam int unsigned PIX_PER_BURST = 8;
   localparam int unsigned LANES         = 4;
   localparam int unsigned LANE_W        = 32;
   localparam int unsigned PIX_W         = 24;

   typedef enum logic [1:0] {
      ReqIdle  = 2'd0,
      ReqIssue = 2'd1,
      ReqDone  = 2'd2
   } req_state_e;

   // Byte address {base, y, x, 2'b00} packed into the controller's
   // burst-aligned address field.
   function automatic logic [30:0] rd_addr(input logic [9:0] base,
                                           input logic [9:0] y,
                                           input logic [9:0] x);
      logic [31:0] byte_addr;
      byte_addr = {base, y, x, 2'b00};
      return {6'b0, byte_addr[27:5], 2'b00};
   endfunction

endpackage

// File: rtl/frame_reader_pixel_unpack_fifo.sv
// pixel_unpack_fifo: DEPTH x 128-bit read-data buffer plus 4-lane unpacker.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   wr_en_i         write one read-data beat (never back-pressured)
//   wr_data_i       read-data beat, four 32-bit lanes
//   pix_o           current 24-bit pixel (0 while buffer empty)
//   pix_valid_o     pixel available
//   pix_ready_i     consumer accepts the pixel
//   free_o          pulse when the last lane of an entry is accepted
//   overflow_o      sticky: a beat was dropped because the buffer was full
module pixel_unpack_fifo #(
   parameter int unsigned DEPTH = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         wr_en_i,
   input  logic [127:0] wr_data_i,
   output logic [23:0]  pix_o,
   output logic         pix_valid_o,
   input  logic         pix_ready_i,
   output logic         free_o,
   output logic         overflow_o
);
   import frame_reader_pkg::*;

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned EW = LANES * PIX_W;

   // Only the 24 pixel bits of each lane are stored.
   logic [EW-1:0]  mem_q [DEPTH];
   logic [EW-1:0]  wr_packed;
   logic [EW-1:0]  rd_word;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [1:0]     lane_q, lane_d;
   logic           overflow_q, overflow_d;
   logic           empty, full, push, pop, accept;
   logic           unused_lane_msbs;

   always_comb begin
      wr_packed = '0;
      for (int l = 0; l < int'(LANES); l++) begin
         wr_packed[l*PIX_W +: PIX_W] = wr_data_i[l*LANE_W +: PIX_W];
      end
   end

   always_comb begin
      unused_lane_msbs = ^{wr_data_i[127:120], wr_data_i[95:88],
                           wr_data_i[63:56], wr_data_i[31:24]};
   end

   always_comb begin
      empty  = (count_q == '0);
      full   = (count_q == CW'(DEPTH));
      accept = !empty && pix_ready_i;
      pop    = accept && (lane_q == 2'd3);
      // A pop in the same cycle frees the slot before the write lands.
      push   = wr_en_i && (!full || pop);
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      lane_d     = lane_q;
      overflow_d = overflow_q | (wr_en_i && !push);
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      if (accept) begin
         lane_d = lane_q + 2'd1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         lane_q     <= 2'd0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         lane_q     <= lane_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: contents are only observed behind count_q.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_packed;
      end
   end

   always_comb begin
      rd_word = mem_q[rd_ptr_q];
      pix_o   = '0;
      if (!empty) begin
         unique case (lane_q)
            2'd0: pix_o = rd_word[0*PIX_W +: PIX_W];
            2'd1: pix_o = rd_word[1*PIX_W +: PIX_W];
            2'd2: pix_o = rd_word[2*PIX_W +: PIX_W];
            2'd3: pix_o = rd_word[3*PIX_W +: PIX_W];
            default: pix_o = '0;
         endcase
      end
      pix_valid_o = !empty;
      free_o      = pop;
      overflow_o  = overflow_q;
   end

endmodule

// File: rtl/frame_reader.sv
// frame_reader: streams the frame buffer out of DDR2 as a 24-bit pixel stream.
// Issues burst read commands into the address FIFO under credit control and
// unpacks returned 128-bit beats into pixels with a valid/ready handshake.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   enable                      stream frames continuously while high
//   af_full                     address FIFO full
//   af_addr_din/af_cmd_din      read command address and opcode
//   af_wr_en                    push one read command (one 8-pixel burst)
//   rdf_valid/rdf_dout          returned read-data beat (not back-pressurable)
//   pixel/pixel_valid/pixel_ready  output pixel stream
//   frame_start                 marks pixel (0,0) of each frame
//   busy                        a frame is being requested or drained
//   overflow                    sticky: a beat arrived while the buffer was full
module frame_reader #(
   parameter logic [9:0]  FB_BASE   = frame_reader_pkg::FB_BASE,
   parameter int unsigned H_PIXELS  = frame_reader_pkg::H_PIXELS,
   parameter int unsigned V_LINES   = frame_reader_pkg::V_LINES,
   parameter int unsigned BUF_DEPTH = frame_reader_pkg::BUF_DEPTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic         af_full,
   output logic [30:0]  af_addr_din,
   output logic [2:0]   af_cmd_din,
   output logic         af_wr_en,
   input  logic         rdf_valid,
   input  logic [127:0] rdf_dout,
   output logic [23:0]  pixel,
   output logic         pixel_valid,
   input  logic         pixel_ready,
   output logic         frame_start,
   output logic         busy,
   output logic         overflow
);
   import frame_reader_pkg::*;

   localparam int unsigned   CW        = $clog2(BUF_DEPTH + 1);
   localparam logic [9:0]    X_LAST    = 10'(H_PIXELS - PIX_PER_BURST);
   localparam logic [9:0]    Y_LAST    = 10'(V_LINES - 1);
   localparam logic [9:0]    OUT_X_END = 10'(H_PIXELS - 1);
   localparam logic [CW-1:0] CRED_FULL = CW'(BUF_DEPTH);

   req_state_e    state_q, state_d;
   logic [9:0]    x_q, x_d;
   logic [9:0]    y_q, y_d;
   logic [9:0]    out_x_q, out_x_d;
   logic [9:0]    out_y_q, out_y_d;
   logic [CW-1:0] credits_q, credits_d;
   logic          issue;
   logic          free;
   logic          accept;

   // Request FSM and address counters.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      issue   = 1'b0;
      unique case (state_q)
         ReqIdle: begin
            if (enable) state_d = ReqIssue;
         end
         ReqIssue: begin
            // Two credits reserve buffer space for both beats of the burst.
            if (!af_full && (credits_q >= CW'(2))) begin
               issue = 1'b1;
               if (x_q < X_LAST) begin
                  x_d = x_q + 10'd8;
               end else begin
                  x_d = '0;
                  if (y_q == Y_LAST) begin
                     y_d     = '0;
                     state_d = ReqDone;
                  end else begin
                     y_d = y_q + 10'd1;
                  end
               end
            end
         end
         ReqDone: begin
            // All credits back means every beat arrived and every pixel left.
            if (credits_q == CRED_FULL) begin
               state_d = enable ? ReqIssue : ReqIdle;
            end
         end
         default: state_d = ReqIdle;
      endcase
   end

   always_comb begin
      credits_d = credits_q;
      if (issue) credits_d = credits_d - CW'(2);
      if (free)  credits_d = credits_d + CW'(1);
   end

   // Output pixel position, used only for frame_start.
   always_comb begin
      accept  = pixel_valid && pixel_ready;
      out_x_d = out_x_q;
      out_y_d = out_y_q;
      if (accept) begin
         if (out_x_q == OUT_X_END) begin
            out_x_d = '0;
            out_y_d = (out_y_q == Y_LAST) ? 10'd0 : out_y_q + 10'd1;
         end else begin
            out_x_d = out_x_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ReqIdle;
         x_q       <= '0;
         y_q       <= '0;
         out_x_q   <= '0;
         out_y_q   <= '0;
         credits_q <= CRED_FULL;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         out_x_q   <= out_x_d;
         out_y_q   <= out_y_d;
         credits_q <= credits_d;
      end
   end

   always_comb begin
      af_wr_en    = issue;
      af_cmd_din  = issue ? DDR_CMD_READ : DDR_CMD_WRITE;
      af_addr_din = issue ? rd_addr(FB_BASE, y_q, x_q) : '0;
      busy        = (state_q != ReqIdle);
      frame_start = pixel_valid && (out_x_q == '0) && (out_y_q == '0);
   end

   pixel_unpack_fifo #(
      .DEPTH(BUF_DEPTH)
   ) u_unpack (
      .clk_i      (clk),
      .rst_ni     (rst),
      .wr_en_i    (rdf_valid),
      .wr_data_i  (rdf_dout),
      .pix_o      (pixel),
      .pix_valid_o(pixel_valid),
      .pix_ready_i(pixel_ready),
      .free_o     (free),
      .overflow_o (overflow)
   );

endmodule

// File: tb/tb_frame_reader.sv
// Self-checking bench for frame_reader on a reduced 16x4 frame with a
// 4-entry buffer. A responder returns two beats per command after a fixed
// latency; expected pixels are queued when beats are driven and compared
// when the DUT hands them over.
module tb_frame_reader;

   localparam int unsigned H     = 16;
   localparam int unsigned V     = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CMDS_PER_FRAME = H * V / 8;
   localparam logic [9:0]  BASE  = 10'b0001000001;
   localparam int          LAT   = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         enable = 1'b0;
   logic         af_full = 1'b0;
   logic         rdf_valid = 1'b0;
   logic [127:0] rdf_dout = '0;
   logic         pixel_ready = 1'b0;
   logic [30:0]  af_addr_din;
   logic [2:0]   af_cmd_din;
   logic         af_wr_en;
   logic [23:0]  pixel;
   logic         pixel_valid;
   logic         frame_start;
   logic         busy;
   logic         overflow;

   always #5 clk = ~clk;

   frame_reader #(
      .FB_BASE  (BASE),
      .H_PIXELS (H),
      .V_LINES  (V),
      .BUF_DEPTH(DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .af_full    (af_full),
      .af_addr_din(af_addr_din),
      .af_cmd_din (af_cmd_din),
      .af_wr_en   (af_wr_en),
      .rdf_valid  (rdf_valid),
      .rdf_dout   (rdf_dout),
      .pixel      (pixel),
      .pixel_valid(pixel_valid),
      .pixel_ready(pixel_ready),
      .frame_start(frame_start),
      .busy       (busy),
      .overflow   (overflow)
   );

   typedef struct {
      int           rdy;
      logic [127:0] data;
      bit           fs;
   } beat_t;

   typedef struct {
      logic [23:0] pix;
      bit          fs;
   } exp_t;

   typedef struct {
      int          full_cycles;
      logic [30:0] exp_addr;
   } vec_t;

   beat_t pend_q[$];
   exp_t  sb_q[$];

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          cmds = 0;
   int          accepted = 0;
   int          fs_count = 0;
   int          owed = 0;
   int          seq = 0;
   int          mx = 0;
   int          my = 0;
   bit          stall_prev = 1'b0;
   logic [23:0] held = '0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_af_wr_en"}, af_wr_en, 0);
      check({tag, "_af_cmd_din"}, af_cmd_din, 0);
      check({tag, "_af_addr_din"}, af_addr_din, 0);
      check({tag, "_pixel"}, pixel, 0);
      check({tag, "_pixel_valid"}, pixel_valid, 0);
      check({tag, "_frame_start"}, frame_start, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_overflow"}, overflow, 0);
   endtask

   function automatic logic [30:0] exp_addr(input int x, input int y);
      logic [31:0] a;
      a = {BASE, 10'(y), 10'(x), 2'b00};
      return {6'b0, a[27:5], 2'b00};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Command and pixel monitor, sampled mid-cycle.
   always @(negedge clk) begin
      beat_t bt;
      exp_t  e;
      if (!rst) begin
         stall_prev = 1'b0;
      end else begin
         if (af_full) check("no_issue_while_full", af_wr_en, 0);
         if (af_wr_en) begin
            check("cmd_read", af_cmd_din, 3'b001);
            check("cmd_addr", af_addr_din, exp_addr(mx, my));
            check("credit_bound", (owed + 2 <= int'(DEPTH)), 1);
            owed += 2;
            for (int b = 0; b < 2; b++) begin
               bt.rdy = cyc + LAT + b;
               bt.fs  = (mx == 0 && my == 0 && b == 0);
               bt.data = '0;
               for (int l = 0; l < 4; l++) begin
                  bt.data[l*32 +: 32] = {8'h80 | 8'(seq), 24'(seq * 40503 + 17)};
                  seq++;
               end
               pend_q.push_back(bt);
            end
            if (mx < int'(H) - 8) begin
               mx += 8;
            end else begin
               mx = 0;
               my = (my == int'(V) - 1) ? 0 : my + 1;
            end
            cmds++;
         end else begin
            check("cmd_idle", af_cmd_din, 3'b000);
         end
         if (stall_prev) begin
            check("hold_valid", pixel_valid, 1);
            check("hold_pixel", pixel, held);
         end
         if (pixel_valid && pixel_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pixel_unexpected: got pixel %0h, expected none", pixel);
            end else begin
               e = sb_q.pop_front();
               check("pixel", pixel, e.pix);
               check("frame_start", frame_start, e.fs);
               if (e.fs) fs_count++;
            end
            accepted++;
            if (accepted % 4 == 0) owed--;
         end
         stall_prev = pixel_valid && !pixel_ready;
         held = pixel;
      end
   end

   // Read-data responder: one beat per cycle at most, in command order.
   always @(posedge clk) begin
      beat_t rb;
      exp_t  re;
      #1;
      rdf_valid = 1'b0;
      if (rst && pend_q.size() > 0 && pend_q[0].rdy <= cyc) begin
         rb = pend_q.pop_front();
         rdf_valid = 1'b1;
         rdf_dout  = rb.data;
         for (int l = 0; l < 4; l++) begin
            re.pix = rb.data[l*32 +: 24];
            re.fs  = rb.fs && (l == 0);
            sb_q.push_back(re);
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic wait_idle(input int limit, input string name);
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < limit && !ok; t++) begin
         @(negedge clk);
         ok = !busy;
      end
      check(name, ok, 1);
   endtask

   task automatic wait_cmds(input int n, input int limit, input string name);
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < limit && !ok; t++) begin
         @(posedge clk);
         ok = (cmds >= n);
      end
      check(name, ok, 1);
   endtask

   initial begin
      vec_t tbl[8];
      bit   found;
      int   a_cmds;
      int   b_cmds;

      // First frame: (x,y) = (0,0),(8,0),(0,1),(8,1),... with af_full stalls.
      tbl[0] = '{0,  31'h0008_0000};
      tbl[1] = '{0,  31'h0008_0004};
      tbl[2] = '{3,  31'h0008_0200};
      tbl[3] = '{0,  31'h0008_0204};
      tbl[4] = '{20, 31'h0008_0400};
      tbl[5] = '{0,  31'h0008_0404};
      tbl[6] = '{5,  31'h0008_0600};
      tbl[7] = '{0,  31'h0008_0604};

      #2 rst = 1'b0;
      #1 check_all_zero("reset");
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      @(posedge clk);
      #1 enable = 1'b1;
      pixel_ready = 1'b1;
      @(negedge clk);
      check("no_issue_same_cycle_as_enable", af_wr_en, 0);
      check("busy_low_before_enable_seen", busy, 0);

      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (tbl[i].full_cycles > 0) begin
            af_full = 1'b1;
            repeat (tbl[i].full_cycles) @(posedge clk);
            #1 af_full = 1'b0;
         end
         found = 1'b0;
         for (int t = 0; t < 80 && !found; t++) begin
            @(negedge clk);
            found = af_wr_en;
         end
         check("tbl_issue_seen", found, 1);
         if (found) check("tbl_addr", af_addr_din, tbl[i].exp_addr);
      end

      // Second frame: stop the consumer mid-frame and let credits run out.
      wait_cmds(CMDS_PER_FRAME + 2, 500, "frame2_started");
      #1 pixel_ready = 1'b0;
      repeat (40) @(posedge clk);
      a_cmds = cmds;
      repeat (40) @(posedge clk);
      b_cmds = cmds;
      check("stall_no_issue", b_cmds == a_cmds, 1);
      check("stall_credits_used", owed >= int'(DEPTH) - 1, 1);
      check("stall_no_overflow", overflow, 0);

      for (int t = 0; t < 300; t++) begin
         @(posedge clk);
         #1 pixel_ready = 1'($urandom_range(0, 1));
      end
      pixel_ready = 1'b1;
      enable = 1'b0;
      wait_idle(3000, "drain_to_idle");
      @(posedge clk);
      check("drain_sb_empty", sb_q.size(), 0);
      check("drain_no_pending", pend_q.size(), 0);
      check("drain_whole_frames", cmds % int'(CMDS_PER_FRAME), 0);
      check("drain_frame_starts", fs_count, cmds / int'(CMDS_PER_FRAME));
      check("drain_pixel_count", accepted, cmds * 8);
      check("drain_overflow", overflow, 0);

      // Reset in the middle of a frame.
      #1 enable = 1'b1;
      wait_cmds(cmds + 3, 200, "restart_cmds");
      #3 rst = 1'b0;
      #1 check_all_zero("async_reset");
      pend_q.delete();
      sb_q.delete();
      mx = 0;
      my = 0;
      owed = 0;
      cmds = 0;
      accepted = 0;
      fs_count = 0;
      @(posedge clk);
      #2 rst = 1'b1;

      found = 1'b0;
      for (int t = 0; t < 50 && !found; t++) begin
         @(negedge clk);
         found = af_wr_en;
      end
      check("post_reset_issue_seen", found, 1);
      if (found) check("post_reset_first_addr", af_addr_din, 31'h0008_0000);

      found = 1'b0;
      for (int t = 0; t < 50 && !found; t++) begin
         @(negedge clk);
         found = rdf_valid;
      end
      check("first_beat_seen", found, 1);
      if (found) begin
         check("valid_not_same_cycle_as_beat", pixel_valid, 0);
         @(negedge clk);
         check("valid_one_cycle_after_beat", pixel_valid, 1);
      end

      @(posedge clk);
      #1 enable = 1'b0;
      wait_idle(3000, "single_frame_idle");
      @(posedge clk);
      check("single_frame_cmds", cmds, CMDS_PER_FRAME);
      check("single_frame_pixels", accepted, H * V);
      check("single_frame_starts", fs_count, 1);
      check("single_frame_sb_empty", sb_q.size(), 0);
      check("single_frame_overflow", overflow, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
